// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data SRAM between the CPU MEM stage and an external host.
// Grants are combinational (0 cycles). Read data returns one cycle after the grant, tagged with its owner.
// Loser is held off: cpu_stall for the CPU, no ext_gnt for the host. Optional DMEM_ARB_STARVE_EN adds anti-starvation.
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic lock_q;   // host held the port last cycle with ext_lock set
  logic pend_q;   // a read was granted last cycle
  logic owner_q;  // owner of that read: 1 = host, 0 = CPU
  logic starved;  // host has waited long enough to be forced in

`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] starve_cnt;

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  // Count consecutive denied host cycles, saturating; any grant or idle cycle restarts the count
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      starve_cnt <= 4'd0;
    end else if (ext_req && !ext_gnt) begin
      if (starve_cnt < 4'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`else
  // Strict CPU priority: the host only gets in when the CPU is idle or a lock is held
  assign starved = 1'b0;
`endif

  // Pick the winner; nothing is granted while reset is asserted
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!arst) begin
      if (ext_req && (!cpu_req || starved || lock_q)) begin
        ext_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = cpu_req && !cpu_gnt && !arst;

  // Steer the winner onto the SRAM port; an idle port drives all zeros
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = !cpu_wen;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = !ext_wen;
    end
  end

  // Remember the lock and which owner the in-flight read belongs to
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lock_q  <= 1'b0;
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      lock_q  <= ext_gnt && ext_lock;
      pend_q  <= mem_ren;
      owner_q <= ext_gnt;
    end
  end

  assign cpu_rvalid = pend_q && !owner_q;
  assign ext_rvalid = pend_q && owner_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against dmem_arbiter with a behavioural single-port SRAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Builds with or without DMEM_ARB_STARVE_EN; expected arbitration follows the build.
module tb_dmem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              arst;
  logic              cpu_req, cpu_wen, ext_req, ext_wen, ext_lock;
  logic [ADDR_W-1:0] cpu_addr, ext_addr;
  logic [DATA_W-1:0] cpu_wdata, ext_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [DATA_W-1:0] cpu_rdata, ext_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_wen, mem_ren;

  logic [DATA_W-1:0] sram [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .arst(arst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_lock(ext_lock), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata)
  );

  // Single-port SRAM model: preloaded under reset, one-cycle read latency
  always @(posedge clk) begin
    if (arst) begin
      sram[10'h010] <= 32'hDEAD_BEEF;
      sram[10'h001] <= 32'h1111_1111;
      sram[10'h002] <= 32'h2222_2222;
      mem_rdata     <= '0;
    end else begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_wen = 0; ext_lock = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
    chk({pfx, "_ext_gnt"},    32'(ext_gnt),    32'd0);
    chk({pfx, "_cpu_stall"},  32'(cpu_stall),  32'd0);
    chk({pfx, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    chk({pfx, "_ext_rvalid"}, 32'(ext_rvalid), 32'd0);
    chk({pfx, "_cpu_rdata"},  cpu_rdata,       32'd0);
    chk({pfx, "_ext_rdata"},  ext_rdata,       32'd0);
    chk({pfx, "_mem_wen"},    32'(mem_wen),    32'd0);
    chk({pfx, "_mem_ren"},    32'(mem_ren),    32'd0);
    chk({pfx, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({pfx, "_mem_wdata"},  mem_wdata,       32'd0);
  endtask

  initial begin
    logic exp_ext;
    // Reset with every requester asking: nothing may leak out
    arst = 1;
    idle_inputs();
    cpu_req = 1; ext_req = 1; ext_lock = 1; cpu_addr = 10'h3FF; cpu_wdata = 32'h1234_5678;
    ext_addr = 10'h155; ext_wdata = 32'h8765_4321;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    next_cycle();
    idle_inputs();
    arst = 0;

    // Idle port drives zeros
    @(negedge clk);
    check_all_zero("idle");
    next_cycle();

    // CPU read of 0x010, host idle
    cpu_req = 1; cpu_addr = 10'h010;
    @(negedge clk);
    chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_mem_ren", 32'(mem_ren), 32'd1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h010);
    chk("rd_cpu_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_ext_rvalid", 32'(ext_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd_cpu_rvalid_once", 32'(cpu_rvalid), 32'd0);
    next_cycle();

    // Alternating owners: CPU reads 0x001, then host reads 0x002
    cpu_req = 1; cpu_addr = 10'h001;
    @(negedge clk);
    chk("alt_cpu_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    cpu_req = 0; ext_req = 1; ext_addr = 10'h002;
    @(negedge clk);
    chk("alt_ext_gnt", 32'(ext_gnt), 32'd1);
    chk("alt_mem_addr", 32'(mem_addr), 32'h002);
    chk("alt_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("alt_cpu_rdata", cpu_rdata, 32'h1111_1111);
    chk("alt_ext_rvalid0", 32'(ext_rvalid), 32'd0);
    next_cycle();
    ext_req = 0;
    @(negedge clk);
    chk("alt_ext_rvalid", 32'(ext_rvalid), 32'd1);
    chk("alt_ext_rdata", ext_rdata, 32'h2222_2222);
    chk("alt_cpu_rvalid0", 32'(cpu_rvalid), 32'd0);
    chk("alt_cpu_rdata0", cpu_rdata, 32'd0);
    next_cycle();
    next_cycle();

    // Contention: CPU writes 0x0AA, host reads 0x055, both held
    cpu_req = 1; cpu_wen = 1; cpu_addr = 10'h0AA; cpu_wdata = 32'hC0C0_0001;
    ext_req = 1; ext_wen = 0; ext_addr = 10'h055;
    for (int i = 0; i < 12; i++) begin
`ifdef DMEM_ARB_STARVE_EN
      exp_ext = ((i % 5) == 4);
`else
      exp_ext = 1'b0;
`endif
      @(negedge clk);
      chk("arb_ext_gnt", 32'(ext_gnt), 32'(exp_ext));
      chk("arb_cpu_gnt", 32'(cpu_gnt), 32'(!exp_ext));
      chk("arb_cpu_stall", 32'(cpu_stall), 32'(exp_ext));
      chk("arb_mem_wen", 32'(mem_wen), 32'(!exp_ext));
      chk("arb_mem_ren", 32'(mem_ren), 32'(exp_ext));
      chk("arb_mem_addr", 32'(mem_addr), exp_ext ? 32'h055 : 32'h0AA);
      chk("arb_mem_wdata", mem_wdata, exp_ext ? 32'd0 : 32'hC0C0_0001);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();

    // Locked host write burst; CPU arrives on the second beat
    for (int k = 0; k < 3; k++) begin
      ext_req = 1; ext_wen = 1; ext_lock = 1;
      ext_addr = ADDR_W'(10'h100 + k); ext_wdata = 32'hA5A5_0000 + 32'(k);
      cpu_req = (k > 0); cpu_wen = 0; cpu_addr = 10'h020;
      @(negedge clk);
      chk("lk_ext_gnt", 32'(ext_gnt), 32'd1);
      chk("lk_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("lk_mem_wen", 32'(mem_wen), 32'd1);
      chk("lk_mem_addr", 32'(mem_addr), 32'h100 + 32'(k));
      chk("lk_mem_wdata", mem_wdata, 32'hA5A5_0000 + 32'(k));
      chk("lk_cpu_stall", 32'(cpu_stall), 32'(k > 0));
      next_cycle();
    end
    ext_req = 0; ext_lock = 0; ext_wen = 0;
    cpu_req = 1; cpu_addr = 10'h102;
    @(negedge clk);
    chk("lk_after_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("lk_after_stall", 32'(cpu_stall), 32'd0);
    chk("lk_after_mem_ren", 32'(mem_ren), 32'd1);
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    chk("lk_readback", cpu_rdata, 32'hA5A5_0002);
    next_cycle();

    // Host granted without lock: CPU takes the next cycle
    ext_req = 1; ext_wen = 1; ext_lock = 0; ext_addr = 10'h200; ext_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("nolk_ext_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();
    cpu_req = 1; cpu_wen = 0; cpu_addr = 10'h010;
    @(negedge clk);
    chk("nolk_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("nolk_ext_gnt0", 32'(ext_gnt), 32'd0);
    chk("nolk_cpu_ren", 32'(mem_ren), 32'd1);
    next_cycle();

    // Reset the cycle after that granted CPU read: its data must never appear
    arst = 1;
    @(negedge clk);
    check_all_zero("rst2");
`ifdef DMEM_ARB_STARVE_EN
    chk("rst2_starve_cnt", 32'(dut.starve_cnt), 32'd0);
`endif
    next_cycle();
    arst = 0;
    @(negedge clk);
    chk("post_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("post_ext_gnt", 32'(ext_gnt), 32'd0);
    chk("post_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
